// File: rtl/dso100fb_pkg.sv
// Shared definitions for the framebuffer fetch blocks.
//   state_e     : fetch sequencer states (encodings are fixed, other blocks decode them)
//   Status*     : bit positions inside the sticky STATUS vector
package dso100fb_pkg;

    typedef enum logic [1:0] {
        StOff   = 2'b00,
        StRun   = 2'b01,
        StDrain = 2'b10,
        StFlush = 2'b11
    } state_e;

    localparam int unsigned StatusW        = 3;
    localparam int unsigned StatusFlip     = 0;
    localparam int unsigned StatusUnderrun = 1;
    localparam int unsigned StatusTimeout  = 2;

endpackage

// File: rtl/dso100fb_status_reg.sv
// Sticky status bits with write-1-to-clear and a masked, registered interrupt.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   set_i         : per-bit set pulses (win over a same-cycle clear)
//   clr_i         : per-bit write-1-to-clear pulses
//   mask_i        : per-bit interrupt enables
//   status_o      : sticky status vector
//   irq_o         : |(status & mask), one cycle behind status
module dso100fb_status_reg #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] set_i,
    input  logic [Width-1:0] clr_i,
    input  logic [Width-1:0] mask_i,
    output logic [Width-1:0] status_o,
    output logic             irq_o
);

    logic [Width-1:0] status_q, status_d;
    logic             irq_q, irq_d;

    always_comb begin
        status_d = (status_q & ~clr_i) | set_i;
        irq_d    = |(status_q & mask_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/dso100fb_fetch_ctrl.sv
// Frame-level sequencer for the framebuffer fetch engine. Restarts the engine only at
// frame boundaries: drains the AHB master, flushes the pixel FIFO, then applies any
// pending flip before re-enabling fetch.
//   CLK, RST_N             : clock, asynchronous active-low reset
//   CFG_*                  : enable level, requested base/end and flip pulse
//   FRAME_START            : start of vertical blank pulse
//   FETCH_ACTIVE           : fetch master has a transfer in progress
//   FIFO_EMPTY, PIXEL_REQ  : underrun detection
//   STATUS_CLEAR, IRQ_MASK : status W1C and interrupt enables
//   FETCH_EN, FETCH_FB_*   : fetch engine control
//   FIFO_FLUSH             : one-cycle FIFO clear
//   STATUS, IRQ, BUSY      : status, interrupt, restart in progress
module dso100fb_fetch_ctrl
    import dso100fb_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CFG_ENABLE,
    input  logic [31:0] CFG_FB_BASE,
    input  logic [31:0] CFG_FB_END,
    input  logic        CFG_FLIP_REQ,
    input  logic        FRAME_START,
    input  logic        FETCH_ACTIVE,
    input  logic        FIFO_EMPTY,
    input  logic        PIXEL_REQ,
    input  logic [2:0]  STATUS_CLEAR,
    input  logic [2:0]  IRQ_MASK,
    output logic        FETCH_EN,
    output logic [31:0] FETCH_FB_BASE,
    output logic [31:0] FETCH_FB_END,
    output logic        FIFO_FLUSH,
    output logic [2:0]  STATUS,
    output logic        IRQ,
    output logic        BUSY
);

    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TmoLast    = CNT_W'(TIMEOUT_CYCLES - 1);
    // Counting one past TmoLast makes the timeout set fire exactly once per DRAIN.
    localparam logic [CNT_W-1:0] TmoMax     = CNT_W'(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [29:0]        act_base_q, act_base_d, act_end_q, act_end_d;
    logic [29:0]        pend_base_q, pend_base_d, pend_end_q, pend_end_d;
    logic               pend_valid_q, pend_valid_d;
    logic               resync_q, resync_d;
    logic               fetch_en_q, fetch_en_d;
    logic               fifo_flush_q, fifo_flush_d;
    logic [StatusW-1:0] status_set;

    logic unused_cfg_lsb;
    assign unused_cfg_lsb = ^{CFG_FB_BASE[1:0], CFG_FB_END[1:0]};

    always_comb begin
        state_d      = state_q;
        settle_d     = '0;
        tmo_d        = '0;
        act_base_d   = act_base_q;
        act_end_d    = act_end_q;
        pend_base_d  = pend_base_q;
        pend_end_d   = pend_end_q;
        pend_valid_d = pend_valid_q;
        resync_d     = resync_q;
        status_set   = '0;

        if (CFG_FLIP_REQ) begin
            pend_base_d  = CFG_FB_BASE[31:2];
            pend_end_d   = CFG_FB_END[31:2];
            pend_valid_d = 1'b1;
        end

        unique case (state_q)
            StOff: begin
                if (CFG_ENABLE && FRAME_START) begin
                    state_d = StDrain;
                    // First enable without an explicit flip uses the live config.
                    if (!pend_valid_q) begin
                        pend_base_d  = CFG_FB_BASE[31:2];
                        pend_end_d   = CFG_FB_END[31:2];
                        pend_valid_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (FIFO_EMPTY && PIXEL_REQ) begin
                    status_set[StatusUnderrun] = 1'b1;
                    resync_d                   = 1'b1;
                end
                if (FRAME_START && (!CFG_ENABLE || pend_valid_q || resync_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                settle_d = FETCH_ACTIVE ? '0 : settle_q + 1'b1;
                tmo_d    = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;
                if (tmo_q == TmoLast) begin
                    status_set[StatusTimeout] = 1'b1;
                end
                if (!FETCH_ACTIVE && (settle_q == SettleLast)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                resync_d = 1'b0;
                if (pend_valid_q) begin
                    // Old pending values are consumed; a same-cycle flip re-arms.
                    act_base_d             = pend_base_q;
                    act_end_d              = pend_end_q;
                    pend_valid_d           = CFG_FLIP_REQ;
                    status_set[StatusFlip] = 1'b1;
                end
                state_d = CFG_ENABLE ? StRun : StOff;
            end
            default: state_d = StOff;
        endcase

        fetch_en_d   = (state_d == StRun);
        fifo_flush_d = (state_d == StFlush);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StOff;
            settle_q     <= '0;
            tmo_q        <= '0;
            act_base_q   <= '0;
            act_end_q    <= '0;
            pend_base_q  <= '0;
            pend_end_q   <= '0;
            pend_valid_q <= 1'b0;
            resync_q     <= 1'b0;
            fetch_en_q   <= 1'b0;
            fifo_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            tmo_q        <= tmo_d;
            act_base_q   <= act_base_d;
            act_end_q    <= act_end_d;
            pend_base_q  <= pend_base_d;
            pend_end_q   <= pend_end_d;
            pend_valid_q <= pend_valid_d;
            resync_q     <= resync_d;
            fetch_en_q   <= fetch_en_d;
            fifo_flush_q <= fifo_flush_d;
        end
    end

    dso100fb_status_reg #(
        .Width (StatusW)
    ) u_status_reg (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .set_i    (status_set),
        .clr_i    (STATUS_CLEAR),
        .mask_i   (IRQ_MASK),
        .status_o (STATUS),
        .irq_o    (IRQ)
    );

    assign FETCH_EN      = fetch_en_q;
    assign FIFO_FLUSH    = fifo_flush_q;
    assign FETCH_FB_BASE = {act_base_q, 2'b00};
    assign FETCH_FB_END  = {act_end_q, 2'b00};
    assign BUSY          = (state_q == StDrain) || (state_q == StFlush);

endmodule

// File: tb/tb_dso100fb_fetch_ctrl.sv
// Directed bench for dso100fb_fetch_ctrl with hand-computed cycle-exact expectations.
module tb_dso100fb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CFG_ENABLE;
    logic [31:0] CFG_FB_BASE;
    logic [31:0] CFG_FB_END;
    logic        CFG_FLIP_REQ;
    logic        FRAME_START;
    logic        FETCH_ACTIVE;
    logic        FIFO_EMPTY;
    logic        PIXEL_REQ;
    logic [2:0]  STATUS_CLEAR;
    logic [2:0]  IRQ_MASK;
    logic        FETCH_EN;
    logic [31:0] FETCH_FB_BASE;
    logic [31:0] FETCH_FB_END;
    logic        FIFO_FLUSH;
    logic [2:0]  STATUS;
    logic        IRQ;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;
    int saw_flush;

    localparam logic [31:0] Base0 = 32'h2000_0000, End0 = 32'h2001_2BFC;
    localparam logic [31:0] Base1 = 32'h2004_0000, End1 = 32'h2005_2BFC;
    localparam logic [31:0] BaseA = 32'h2008_0000, EndA = 32'h2009_2BFC;
    localparam logic [31:0] BaseB = 32'h200C_0000, EndB = 32'h200D_2BFC;

    always #5 CLK = ~CLK;

    dso100fb_fetch_ctrl dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .CFG_ENABLE    (CFG_ENABLE),
        .CFG_FB_BASE   (CFG_FB_BASE),
        .CFG_FB_END    (CFG_FB_END),
        .CFG_FLIP_REQ  (CFG_FLIP_REQ),
        .FRAME_START   (FRAME_START),
        .FETCH_ACTIVE  (FETCH_ACTIVE),
        .FIFO_EMPTY    (FIFO_EMPTY),
        .PIXEL_REQ     (PIXEL_REQ),
        .STATUS_CLEAR  (STATUS_CLEAR),
        .IRQ_MASK      (IRQ_MASK),
        .FETCH_EN      (FETCH_EN),
        .FETCH_FB_BASE (FETCH_FB_BASE),
        .FETCH_FB_END  (FETCH_FB_END),
        .FIFO_FLUSH    (FIFO_FLUSH),
        .STATUS        (STATUS),
        .IRQ           (IRQ),
        .BUSY          (BUSY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N        = 1'b0;
        CFG_ENABLE   = 1'b0;
        CFG_FB_BASE  = '0;
        CFG_FB_END   = '0;
        CFG_FLIP_REQ = 1'b0;
        FRAME_START  = 1'b0;
        FETCH_ACTIVE = 1'b0;
        FIFO_EMPTY   = 1'b0;
        PIXEL_REQ    = 1'b0;
        STATUS_CLEAR = '0;
        IRQ_MASK     = '0;
        step();
        step();
        check("rst_fetch_en", 32'(FETCH_EN), 0);
        check("rst_base", FETCH_FB_BASE, 0);
        check("rst_end", FETCH_FB_END, 0);
        check("rst_flush", 32'(FIFO_FLUSH), 0);
        check("rst_status", 32'(STATUS), 0);
        check("rst_irq", 32'(IRQ), 0);
        check("rst_busy", 32'(BUSY), 0);
        RST_N = 1'b1;
        step();

        // 1: first enable, implicit flip, no bus activity
        CFG_ENABLE  = 1'b1;
        CFG_FB_BASE = Base0;
        CFG_FB_END  = End0;
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        check("t1_drain1_fe", 32'(FETCH_EN), 0);
        check("t1_drain1_busy", 32'(BUSY), 1);
        step();
        check("t1_drain2_flush", 32'(FIFO_FLUSH), 0);
        check("t1_drain2_busy", 32'(BUSY), 1);
        step();
        check("t1_flush", 32'(FIFO_FLUSH), 1);
        check("t1_flush_fe", 32'(FETCH_EN), 0);
        step();
        check("t1_run_fe", 32'(FETCH_EN), 1);
        check("t1_run_flush", 32'(FIFO_FLUSH), 0);
        check("t1_base", FETCH_FB_BASE, Base0);
        check("t1_end", FETCH_FB_END, End0);
        check("t1_status", 32'(STATUS), 32'b001);
        STATUS_CLEAR = 3'b111;
        step();
        STATUS_CLEAR = 3'b000;
        check("t1_status_clr", 32'(STATUS), 0);

        // 2: flip with the bus busy for 10 cycles after FRAME_START
        CFG_FB_BASE  = Base1;
        CFG_FB_END   = End1;
        CFG_FLIP_REQ = 1'b1;
        step();
        CFG_FLIP_REQ = 1'b0;
        check("t2_flip_no_effect", FETCH_FB_BASE, Base0);
        check("t2_still_run", 32'(FETCH_EN), 1);
        FRAME_START  = 1'b1;
        FETCH_ACTIVE = 1'b1;
        step();
        FRAME_START  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("t2_busy_fe", 32'(FETCH_EN), 0);
            check("t2_busy_base", FETCH_FB_BASE, Base0);
            step();
        end
        FETCH_ACTIVE = 1'b0;
        check("t2_c10_fe", 32'(FETCH_EN), 0);
        step();
        check("t2_c11_flush", 32'(FIFO_FLUSH), 0);
        check("t2_c11_base", FETCH_FB_BASE, Base0);
        step();
        check("t2_c12_flush", 32'(FIFO_FLUSH), 1);
        check("t2_c12_base", FETCH_FB_BASE, Base0);
        step();
        check("t2_c13_fe", 32'(FETCH_EN), 1);
        check("t2_base", FETCH_FB_BASE, Base1);
        check("t2_end", FETCH_FB_END, End1);
        check("t2_status", 32'(STATUS), 32'b001);

        // 3: underrun, IRQ, resync restart without flip
        STATUS_CLEAR = 3'b111;
        step();
        STATUS_CLEAR = 3'b000;
        IRQ_MASK     = 3'b010;
        FIFO_EMPTY   = 1'b1;
        PIXEL_REQ    = 1'b1;
        step();
        FIFO_EMPTY   = 1'b0;
        PIXEL_REQ    = 1'b0;
        check("t3_underrun", 32'(STATUS), 32'b010);
        check("t3_irq_lat", 32'(IRQ), 0);
        step();
        check("t3_irq", 32'(IRQ), 1);
        check("t3_stay_run", 32'(FETCH_EN), 1);
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        check("t3_resync_drain", 32'(FETCH_EN), 0);
        step();
        step();
        check("t3_flush", 32'(FIFO_FLUSH), 1);
        step();
        check("t3_run", 32'(FETCH_EN), 1);
        check("t3_base", FETCH_FB_BASE, Base1);
        check("t3_status", 32'(STATUS), 32'b010);
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        check("t3_resync_cleared", 32'(FETCH_EN), 1);
        IRQ_MASK     = 3'b000;
        STATUS_CLEAR = 3'b111;
        step();
        STATUS_CLEAR = 3'b000;

        // 4: disable; flush-time emptiness is not an underrun
        CFG_ENABLE  = 1'b0;
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
        FIFO_EMPTY  = 1'b1;
        PIXEL_REQ   = 1'b1;
        check("t4_drain_fe", 32'(FETCH_EN), 0);
        check("t4_drain_busy", 32'(BUSY), 1);
        step();
        step();
        check("t4_flush", 32'(FIFO_FLUSH), 1);
        step();
        check("t4_off_busy", 32'(BUSY), 0);
        check("t4_off_fe", 32'(FETCH_EN), 0);
        for (int i = 0; i < 3; i++) begin
            FRAME_START = 1'b1;
            step();
            FRAME_START = 1'b0;
            step();
            check("t4_off_frame_fe", 32'(FETCH_EN), 0);
            check("t4_off_frame_busy", 32'(BUSY), 0);
        end
        check("t4_status", 32'(STATUS), 0);
        FIFO_EMPTY = 1'b0;
        PIXEL_REQ  = 1'b0;

        // 5: bus stuck -> drain timeout, then recovery
        CFG_ENABLE   = 1'b1;
        FETCH_ACTIVE = 1'b1;
        FRAME_START  = 1'b1;
        step();
        FRAME_START  = 1'b0;
        saw_flush    = 0;
        for (int i = 0; i < 1022; i++) begin
            step();
            if (FIFO_FLUSH) saw_flush = 1;
        end
        check("t5_c1023_tmo", 32'(STATUS[2]), 0);
        check("t5_c1023_busy", 32'(BUSY), 1);
        check("t5_no_flush", saw_flush, 0);
        step();
        check("t5_c1024_tmo", 32'(STATUS[2]), 0);
        step();
        check("t5_c1025_tmo", 32'(STATUS[2]), 1);
        check("t5_still_drain", 32'(FIFO_FLUSH), 0);
        FETCH_ACTIVE = 1'b0;
        step();
        step();
        check("t5_flush", 32'(FIFO_FLUSH), 1);
        step();
        check("t5_run", 32'(FETCH_EN), 1);
        check("t5_status", 32'(STATUS), 32'b101);
        check("t5_base", FETCH_FB_BASE, Base1);
        STATUS_CLEAR = 3'b111;
        step();
        STATUS_CLEAR = 3'b000;

        // 6: flip coincident with FLUSH, clear coincident with flip set
        CFG_FB_BASE  = BaseA;
        CFG_FB_END   = EndA;
        CFG_FLIP_REQ = 1'b1;
        step();
        CFG_FLIP_REQ = 1'b0;
        FRAME_START  = 1'b1;
        step();
        FRAME_START  = 1'b0;
        step();
        step();
        check("t6_flush", 32'(FIFO_FLUSH), 1);
        CFG_FB_BASE  = BaseB;
        CFG_FB_END   = EndB;
        CFG_FLIP_REQ = 1'b1;
        STATUS_CLEAR = 3'b001;
        step();
        CFG_FLIP_REQ = 1'b0;
        STATUS_CLEAR = 3'b000;
        check("t6_base_a", FETCH_FB_BASE, BaseA);
        check("t6_end_a", FETCH_FB_END, EndA);
        check("t6_status_set_wins", 32'(STATUS), 32'b001);
        STATUS_CLEAR = 3'b111;
        FRAME_START  = 1'b1;
        step();
        STATUS_CLEAR = 3'b000;
        FRAME_START  = 1'b0;
        check("t6_pending_restart", 32'(FETCH_EN), 0);
        check("t6_status_clr", 32'(STATUS), 0);
        step();
        step();
        check("t6_flush2_base", FETCH_FB_BASE, BaseA);
        step();
        check("t6_base_b", FETCH_FB_BASE, BaseB);
        check("t6_end_b", FETCH_FB_END, EndB);
        check("t6_status2", 32'(STATUS), 32'b001);

        // 7: reset in the middle of DRAIN
        CFG_ENABLE   = 1'b0;
        FETCH_ACTIVE = 1'b1;
        FRAME_START  = 1'b1;
        step();
        FRAME_START  = 1'b0;
        step();
        check("t7_drain_busy", 32'(BUSY), 1);
        RST_N = 1'b0;
        #1;
        check("t7_rst_busy", 32'(BUSY), 0);
        check("t7_rst_base", FETCH_FB_BASE, 0);
        check("t7_rst_status", 32'(STATUS), 0);
        step();
        RST_N        = 1'b1;
        FETCH_ACTIVE = 1'b0;
        step();
        check("t7_off_fe", 32'(FETCH_EN), 0);
        check("t7_off_busy", 32'(BUSY), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
